// File: rtl/nand_reduce_seq_v.sv
// nand_reduce_seq_v: WIDTH-input NAND computed on one shared external NAND2.
// Build option: define NAND_SEQ_EARLY_EXIT_EN to finish at the first 0 bit.

module nand_reduce_seq_v #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_operand,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_result,
    output logic             o_busy,
    output logic             o_gate_en,
    output logic             o_gate_a,
    output logic             o_gate_b,
    input  logic             i_gate_f
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        NAND,
        INV,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op;
    logic             acc;
    logic             t;
    logic [KW-1:0]    k;
    logic             last;
    logic             finish;

    assign last = (k == K_LAST);

    // A NAND step ends the run on the last bit, or on a found 0 bit
    // when early exit is built in (the gate output is then already 1).
`ifdef NAND_SEQ_EARLY_EXIT_EN
    assign finish = last || i_gate_f;
`else
    assign finish = last;
`endif

    assign o_start_ready = (state == IDLE);
    assign o_busy        = (state != IDLE);

    // Gate inputs: NAND step uses acc/op[k], NOT step feeds t to both pins
    always_comb begin
        o_gate_en = 1'b0;
        o_gate_a  = 1'b0;
        o_gate_b  = 1'b0;
        unique case (1'b1)
            (state == NAND): begin
                o_gate_en = 1'b1;
                o_gate_a  = acc;
                o_gate_b  = op[k];
            end
            (state == INV): begin
                o_gate_en = 1'b1;
                o_gate_a  = t;
                o_gate_b  = t;
            end
            default: begin
                o_gate_en = 1'b0;
            end
        endcase
    end

    // Sequencer: accept, alternate NAND/NOT evaluations, hold result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            op             <= '0;
            acc            <= 1'b0;
            t              <= 1'b0;
            k              <= '0;
            o_result       <= 1'b0;
            o_result_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start_valid) begin
                        op    <= i_operand;
                        acc   <= i_operand[0];
                        k     <= KW'(1);
                        state <= NAND;
                    end
                end
                NAND: begin
                    if (finish) begin
                        o_result       <= i_gate_f;
                        o_result_valid <= 1'b1;
                        state          <= DONE;
                    end else begin
                        t     <= i_gate_f;
                        state <= INV;
                    end
                end
                INV: begin
                    acc   <= i_gate_f;
                    k     <= k + KW'(1);
                    state <= NAND;
                end
                DONE: begin
                    if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
